adder_subtracter: RTL and testbench

- Registered 32-bit two's-complement adder/subtracter; `mode` selects a+b or a−b.
- Result and status flags are captured on the rising clock edge.
- Sits as a datapath arithmetic unit between operand registers and downstream consumers; also serves as the DUT for the top-level testbench harness.

---
 rtl/adder_subtracter_if.sv | 23 ++
 rtl/adder_subtracter.sv | 46 ++++
 tb/tb_adder_subtracter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adder_subtracter_if.sv
// Operand/result bundle for the registered adder/subtracter.
// The driver of a, b and mode uses master; the arithmetic unit uses slave.
interface adder_subtracter_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             zero;

  modport master (
    output a, b, mode,
    input  sum, carry, overflow, zero
  );

  modport slave (
    input  a, b, mode,
    output sum, carry, overflow, zero
  );
endinterface

// File: rtl/adder_subtracter.sv
// Registered two's-complement adder/subtracter with carry, overflow and zero flags.
// Subtraction reuses the single adder as a + ~b + 1.
module adder_subtracter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  adder_subtracter_if.slave  bus
);
  logic [WIDTH-1:0] eff_b;
  logic [WIDTH:0]   full_res;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;

  always_comb begin
    eff_b      = bus.mode ? ~bus.b : bus.b;
    full_res   = {1'b0, bus.a} + {1'b0, eff_b} + {{WIDTH{1'b0}}, bus.mode};
    sum_d      = full_res[WIDTH-1:0];
    carry_d    = full_res[WIDTH];
    // Overflow: operands agree in sign but the result does not.
    overflow_d = (bus.a[WIDTH-1] == eff_b[WIDTH-1]) && (sum_d[WIDTH-1] != bus.a[WIDTH-1]);
    zero_d     = (sum_d == '0);
  end

  // zero resets low on purpose: flags read as invalid until the first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.sum      = sum_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.zero     = zero_q;
endmodule

// File: tb/tb_adder_subtracter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops one per clock
// one cycle after the operands were presented.
module tb_adder_subtracter;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  prev_exp;

  adder_subtracter_if #(.WIDTH(W)) bus_if ();

  adder_subtracter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t observed();
    exp_t r;
    r.sum = bus_if.sum;
    r.c   = bus_if.carry;
    r.o   = bus_if.overflow;
    r.z   = bus_if.zero;
    return r;
  endfunction

  task automatic check(input string nm, input exp_t got, input exp_t want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got sum=%h c=%b o=%b z=%b, want sum=%h c=%b o=%b z=%b",
               nm, got.sum, got.c, got.o, got.z, want.sum, want.c, want.o, want.z);
    end
  endtask

  // Independent reference: wide signed arithmetic for overflow, unsigned compare for borrow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      r;
    logic [W:0]  u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = m ? sa - sb : sa + sb;
    u  = m ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    e.sum = u[W-1:0];
    e.c   = m ? (a >= b) : u[W];
    e.o   = (r != longint'($signed(u[W-1:0])));
    e.z   = (e.sum == '0);
    return e;
  endfunction

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input exp_t e, input string nm);
    @(negedge clk);
    bus_if.a    = a;
    bus_if.b    = b;
    bus_if.mode = m;
    exp_q.push_back(e);
    name_q.push_back(nm);
    prev_exp = e;
  endtask

  // Monitor: outputs are valid every cycle out of reset; pop one expectation per edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        check(name_q.pop_front(), observed(), exp_q.pop_front());
      end
    end
  end

  initial begin
    exp_t zero_e;
    zero_e   = '0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_if.a = 32'd5;
    bus_if.b = 32'd3;
    bus_if.mode = 1'b0;

    #7;
    check("reset_hold", observed(), zero_e);
    @(posedge clk); #1;
    check("reset_hold_after_edge", observed(), zero_e);

    // Release reset; first edge captures 5+3.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{sum: 32'd8, c: 1'b0, o: 1'b0, z: 1'b0});
    name_q.push_back("first_capture");

    apply(32'd100, 32'd23, 1'b0, '{sum: 32'd123, c: 1'b0, o: 1'b0, z: 1'b0}, "add_basic");
    #4;
    check("latency_not_before_edge", observed(), '{sum: 32'd8, c: 1'b0, o: 1'b0, z: 1'b0});

    apply(32'd50, 32'd20, 1'b1, '{sum: 32'd30, c: 1'b1, o: 1'b0, z: 1'b0}, "sub_no_borrow");
    apply(32'd20, 32'd50, 1'b1, '{sum: 32'hFFFF_FFE2, c: 1'b0, o: 1'b0, z: 1'b0}, "sub_borrow");
    apply(32'hFFFF_FFFF, 32'd1, 1'b0, '{sum: 32'd0, c: 1'b1, o: 1'b0, z: 1'b1}, "add_wrap_zero");
    apply(32'd7, 32'd7, 1'b1, '{sum: 32'd0, c: 1'b1, o: 1'b0, z: 1'b1}, "sub_zero");
    apply(32'h7FFF_FFFF, 32'd1, 1'b0, '{sum: 32'h8000_0000, c: 1'b0, o: 1'b1, z: 1'b0}, "add_ovf");
    apply(32'h8000_0000, 32'd1, 1'b1, '{sum: 32'h7FFF_FFFF, c: 1'b1, o: 1'b1, z: 1'b0}, "sub_ovf");
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        apply(32'd10, 32'd4, 1'b0, '{sum: 32'd14, c: 1'b0, o: 1'b0, z: 1'b0}, "toggle_add");
      else
        apply(32'd10, 32'd4, 1'b1, '{sum: 32'd6, c: 1'b1, o: 1'b0, z: 1'b0}, "toggle_sub");
    end

    // Mid-cycle reset: pending operands must be discarded, outputs clear immediately.
    @(negedge clk);
    bus_if.a = 32'd5;
    bus_if.b = 32'd3;
    bus_if.mode = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", observed(), zero_e);
    @(posedge clk); #1;
    check("async_reset_held", observed(), zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{sum: 32'd8, c: 1'b0, o: 1'b0, z: 1'b0});
    name_q.push_back("post_reset_capture");

    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rm;
      ra = $urandom();
      rb = (i % 8 == 0) ? ra : $urandom();
      rm = $urandom_range(0, 1) != 0;
      apply(ra, rb, rm, model(ra, rb, rm), "random");
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
